mesh_port_arbiter: RTL and testbench

MESH_PORT_ARBITER -- requirements
Module: mesh_port_arbiter

---
 rtl/mesh_port_arbiter.sv | 114 +++++++++++
 tb/tb_mesh_port_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mesh_port_arbiter.sv
// Round-robin arbiter forwarding one packet per grant from num_req input FIFOs
// to a single mesh router output port, with downstream backpressure and a packet counter.
module mesh_port_arbiter #(
  parameter int pckg_sz = 41,
  parameter int num_req = 4,
  parameter int cnt_w   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [num_req-1:0]         pndng_in,
  input  logic [num_req*pckg_sz-1:0] data_in,
  output logic [num_req-1:0]         pop,
  output logic [pckg_sz-1:0]         data_out,
  output logic                       push,
  input  logic                       full_out,
  output logic [num_req-1:0]         gnt,
  output logic [cnt_w-1:0]           pkt_cnt
);

  localparam int idx_w = (num_req > 1) ? $clog2(num_req) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state, state_next;
  logic [idx_w-1:0]   gnt_idx, gnt_idx_next;
  logic [idx_w-1:0]   last_gnt, last_gnt_next;
  logic [num_req-1:0] gnt_next;
  logic [cnt_w-1:0]   pkt_cnt_next;
  logic [idx_w-1:0]   pick_idx;
  logic               pick_found;
  logic [pckg_sz-1:0] slices [num_req];

  for (genvar i = 0; i < num_req; i++) begin : g_slice
    assign slices[i] = data_in[i*pckg_sz +: pckg_sz];
  end

  // Scan from the requester after the last one served, wrapping around.
  always_comb begin
    int               cand;
    logic [idx_w-1:0] cand_idx;
    pick_idx   = '0;
    pick_found = 1'b0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 1; k <= num_req; k++) begin
      cand = int'(last_gnt) + k;
      if (cand >= num_req) cand = cand - num_req;
      cand_idx = idx_w'(cand);
      if (!pick_found && pndng_in[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_next    = state;
    gnt_next      = gnt;
    gnt_idx_next  = gnt_idx;
    last_gnt_next = last_gnt;
    pkt_cnt_next  = pkt_cnt;
    push          = 1'b0;
    pop           = '0;
    data_out      = '0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next         = SEND;
          gnt_next           = '0;
          gnt_next[pick_idx] = 1'b1;
          gnt_idx_next       = pick_idx;
        end
      end
      SEND: begin
        if (!pndng_in[gnt_idx]) begin
          state_next = IDLE;
          gnt_next   = '0;
        end else if (!full_out) begin
          push          = 1'b1;
          pop           = gnt;
          data_out      = slices[gnt_idx];
          last_gnt_next = gnt_idx;
          pkt_cnt_next  = pkt_cnt + 1'b1;
          gnt_next      = '0;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // A reset cycle must never move a packet, even mid-grant.
    if (reset) begin
      push     = 1'b0;
      pop      = '0;
      data_out = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_idx  <= '0;
      last_gnt <= idx_w'(num_req - 1);
      pkt_cnt  <= '0;
    end else begin
      state    <= state_next;
      gnt      <= gnt_next;
      gnt_idx  <= gnt_idx_next;
      last_gnt <= last_gnt_next;
      pkt_cnt  <= pkt_cnt_next;
    end
  end

endmodule

// File: tb/tb_mesh_port_arbiter.sv
// Testbench for mesh_port_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_mesh_port_arbiter;

  localparam int PW = 41;
  localparam int N  = 4;
  localparam int CW = 8;  // narrow counter so the wrap is reachable quickly

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    pndng_in;
  logic [N*PW-1:0] data_in;
  logic [N-1:0]    pop;
  logic [PW-1:0]   data_out;
  logic            push;
  logic            full_out;
  logic [N-1:0]    gnt;
  logic [CW-1:0]   pkt_cnt;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Behavioural model: who holds the grant, who was served last, how many served.
  bit m_busy = 1'b0;
  int m_g    = 0;
  int m_last = N - 1;
  int m_cnt  = 0;

  mesh_port_arbiter #(.pckg_sz(PW), .num_req(N), .cnt_w(CW)) dut (
    .clk(clk), .reset(reset), .pndng_in(pndng_in), .data_in(data_in),
    .pop(pop), .data_out(data_out), .push(push), .full_out(full_out),
    .gnt(gnt), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] p, input logic f, input logic r,
                               input logic [N*PW-1:0] d);
    @(posedge clk);
    #1;
    pndng_in = p;
    full_out = f;
    reset    = r;
    data_in  = d;
    @(negedge clk);
  endtask

  // Compare against the model at each negedge, then advance the model by one edge.
  always @(negedge clk) begin
    if (check_en) begin
      logic [N-1:0]  e_pop, e_gnt;
      logic [PW-1:0] e_data;
      logic          e_push;
      e_push = 1'b0;
      e_pop  = '0;
      e_data = '0;
      e_gnt  = m_busy ? (N'(1) << m_g) : '0;
      if (m_busy && !reset && ((pndng_in >> m_g) & 1) != 0 && !full_out) begin
        e_push = 1'b1;
        e_pop  = N'(1) << m_g;
        e_data = PW'(data_in >> (m_g * PW));
      end
      checkOutput("model_push", 64'(push), 64'(e_push));
      checkOutput("model_pop", 64'(pop), 64'(e_pop));
      checkOutput("model_data", 64'(data_out), 64'(e_data));
      checkOutput("model_gnt", 64'(gnt), 64'(e_gnt));
      checkOutput("model_cnt", 64'(pkt_cnt), 64'(m_cnt));
      if (reset) begin
        m_busy = 1'b0;
        m_last = N - 1;
        m_cnt  = 0;
      end else if (!m_busy) begin
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (m_last + k) % N;
          if (!m_busy && ((pndng_in >> idx) & 1) != 0) begin
            m_busy = 1'b1;
            m_g    = idx;
          end
        end
      end else if (((pndng_in >> m_g) & 1) == 0) begin
        m_busy = 1'b0;
      end else if (!full_out) begin
        m_last = m_g;
        m_cnt  = (m_cnt + 1) % (1 << CW);
        m_busy = 1'b0;
      end
    end
  end

  initial begin
    logic [N*PW-1:0] d;
    logic [N-1:0]    rr_pops [5];
    int              rr_n;
    rr_pops[0] = 4'b0001; rr_pops[1] = 4'b0010; rr_pops[2] = 4'b0100;
    rr_pops[3] = 4'b1000; rr_pops[4] = 4'b0001;
    reset    = 1'b1;
    pndng_in = '0;
    full_out = 1'b0;
    data_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_en = 1'b1;
    reset    = 1'b0;
    @(negedge clk);
    checkOutput("reset_gnt", 64'(gnt), 64'h0);
    checkOutput("reset_cnt", 64'(pkt_cnt), 64'h0);
    checkOutput("reset_push", 64'(push), 64'h0);

    // Single packet from requester 0.
    d = '0;
    d[PW-1:0] = 41'h1_0000_00AB;
    applyStimulus(4'b0001, 1'b0, 1'b0, d);
    checkOutput("single_idle_gnt", 64'(gnt), 64'h0);
    applyStimulus(4'b0001, 1'b0, 1'b0, d);
    checkOutput("single_gnt", 64'(gnt), 64'h1);
    checkOutput("single_push", 64'(push), 64'h1);
    checkOutput("single_pop", 64'(pop), 64'h1);
    checkOutput("single_data", 64'(data_out), 64'h1_0000_00AB);
    applyStimulus(4'b0000, 1'b0, 1'b0, d);
    checkOutput("single_cnt", 64'(pkt_cnt), 64'h1);
    checkOutput("single_gnt_clr", 64'(gnt), 64'h0);

    // Round robin with all requesters pending.
    for (int i = 0; i < N; i++) d[i*PW +: PW] = PW'(64'h100 + i);
    applyStimulus(4'b0000, 1'b0, 1'b1, d);
    applyStimulus(4'b1111, 1'b0, 1'b0, d);
    rr_n = 0;
    for (int s = 1; s <= 10; s++) begin
      applyStimulus(4'b1111, 1'b0, 1'b0, d);
      if (s % 2 == 1) begin
        checkOutput("rr_push", 64'(push), 64'h1);
        checkOutput("rr_pop", 64'(pop), 64'(rr_pops[rr_n]));
        rr_n++;
      end else begin
        checkOutput("rr_idle_push", 64'(push), 64'h0);
      end
    end
    checkOutput("rr_cnt", 64'(pkt_cnt), 64'd5);

    // Serve requester 1, then hold requester 2 under backpressure.
    applyStimulus(4'b1111, 1'b0, 1'b0, d);
    checkOutput("bp_pre_pop", 64'(pop), 64'h2);
    applyStimulus(4'b0100, 1'b1, 1'b0, d);
    for (int s = 0; s < 5; s++) begin
      applyStimulus(4'b0100, 1'b1, 1'b0, d);
      checkOutput("bp_gnt", 64'(gnt), 64'h4);
      checkOutput("bp_push", 64'(push), 64'h0);
      checkOutput("bp_pop", 64'(pop), 64'h0);
    end
    applyStimulus(4'b0100, 1'b0, 1'b0, d);
    checkOutput("bp_rel_push", 64'(push), 64'h1);
    checkOutput("bp_rel_pop", 64'(pop), 64'h4);
    checkOutput("bp_rel_data", 64'(data_out), 64'h102);
    applyStimulus(4'b0000, 1'b0, 1'b0, d);
    checkOutput("bp_cnt", 64'(pkt_cnt), 64'd7);

    // Withdrawal while requester 1 is granted.
    applyStimulus(4'b0010, 1'b0, 1'b0, d);
    applyStimulus(4'b0000, 1'b0, 1'b0, d);
    checkOutput("wd_gnt", 64'(gnt), 64'h2);
    checkOutput("wd_push", 64'(push), 64'h0);
    checkOutput("wd_pop", 64'(pop), 64'h0);
    applyStimulus(4'b1111, 1'b0, 1'b0, d);
    checkOutput("wd_gnt_clr", 64'(gnt), 64'h0);
    checkOutput("wd_cnt", 64'(pkt_cnt), 64'd7);

    // Next grant goes to 3 (after last served 2); reset lands mid-SEND.
    applyStimulus(4'b1111, 1'b0, 1'b1, d);
    checkOutput("rst_send_gnt", 64'(gnt), 64'h8);
    checkOutput("rst_send_push", 64'(push), 64'h0);
    checkOutput("rst_send_pop", 64'(pop), 64'h0);
    checkOutput("rst_send_data", 64'(data_out), 64'h0);
    applyStimulus(4'b1001, 1'b0, 1'b0, d);
    checkOutput("rst_clr_gnt", 64'(gnt), 64'h0);
    checkOutput("rst_clr_cnt", 64'(pkt_cnt), 64'h0);
    applyStimulus(4'b1001, 1'b0, 1'b0, d);
    checkOutput("rst_first_gnt", 64'(gnt), 64'h1);
    checkOutput("rst_first_pop", 64'(pop), 64'h1);

    // Counter wrap: one transfer every two cycles.
    applyStimulus(4'b0000, 1'b0, 1'b1, d);
    applyStimulus(4'b1111, 1'b0, 1'b0, d);
    for (int s = 1; s <= 510; s++) applyStimulus(4'b1111, 1'b0, 1'b0, d);
    checkOutput("wrap_max", 64'(pkt_cnt), 64'hFF);
    repeat (2) applyStimulus(4'b1111, 1'b0, 1'b0, d);
    checkOutput("wrap_zero", 64'(pkt_cnt), 64'h0);

    // Randomized traffic with occasional backpressure and resets.
    for (int s = 0; s < 3000; s++) begin
      for (int b = 0; b < N*PW; b++) d[b] = 1'($urandom_range(0, 1));
      applyStimulus(N'($urandom_range(0, (1 << N) - 1)),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 99) == 0), d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
